// File: rtl/trng_conditioner_pkg.sv
// Shared constants for the TRNG conditioner: block/digest geometry and FSM encodings.
package trng_conditioner_pkg;

  localparam int BLOCK_BITS   = 512;
  localparam int DIGEST_BITS  = 256;
  localparam int WORD_W       = 32;
  localparam int DIGEST_WORDS = 8;

  localparam int CNT_W = $clog2(BLOCK_BITS + 1);
  localparam int IDX_W = $clog2(DIGEST_WORDS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HASH  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/trng_conditioner_rct_monitor.sv
// Repetition-count health test: flags a run of CUTOFF identical accepted bits.
module trng_rct_monitor #(
  parameter int CUTOFF = 34
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid,
  input  logic bit_in,
  output logic trip
);

  localparam int RUN_W = $clog2(CUTOFF + 1);

  logic [RUN_W-1:0] run_reg;
  logic [RUN_W-1:0] run_next;
  logic             last_reg;

  always_comb begin
    run_next = RUN_W'(1);
    if (run_reg != '0 && bit_in == last_reg) begin
      run_next = run_reg + 1'b1;
    end
  end

  assign trip = bit_valid && (run_next == RUN_W'(CUTOFF));

  // The run restarts after a trip so the counter never exceeds CUTOFF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_reg  <= '0;
      last_reg <= 1'b0;
    end else if (bit_valid) begin
      last_reg <= bit_in;
      run_reg  <= trip ? '0 : run_next;
    end
  end

endmodule

// File: rtl/trng_conditioner.sv
// Collects raw TRNG bits into 512-bit blocks, hashes each via sha256_ip, drains digests as 32-bit words.
// Optional repetition-count health test enabled by defining TRNG_COND_HEALTH_EN.
module trng_conditioner
  import trng_conditioner_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int RCT_CUTOFF     = 34,
  parameter int OVF_CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   raw_bit,
  input  logic                   raw_valid,
  output logic                   sha_go,
  output logic [BLOCK_BITS-1:0]  sha_data_in,
  input  logic [DIGEST_BITS-1:0] sha_data_out,
  input  logic                   sha_done,
  output logic [WORD_W-1:0]      rnd_data,
  output logic                   rnd_valid,
  input  logic                   rnd_ready,
  output logic [OVF_CNT_W-1:0]   ovf_cnt,
  output logic                   err_timeout,
  output logic                   health_fail
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGEST_WORDS - 1);

  logic [BLOCK_BITS-1:0]  coll_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic [OVF_CNT_W-1:0]   ovf_reg;
  logic [1:0]             state_reg;
  logic [TMR_W-1:0]       tmr_reg;
  logic                   go_reg;
  logic [BLOCK_BITS-1:0]  blk_reg;
  logic [DIGEST_BITS-1:0] digest_reg;
  logic [IDX_W-1:0]       idx_reg;
  logic                   valid_reg;
  logic                   err_reg;
  logic                   rct_trip;

  logic accept;
  logic full;
  logic launch;
  logic shift_in;
  logic drop;

  assign accept   = en && raw_valid;
  assign full     = (cnt_reg == CNT_W'(BLOCK_BITS));
  assign launch   = (state_reg == ST_IDLE) && full && !health_fail && !rct_trip;
  // The launch edge frees the buffer, so a bit arriving then starts the next block.
  assign shift_in = accept && (launch || !full);
  assign drop     = accept && full && !launch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_reg <= '0;
      cnt_reg  <= '0;
    end else if (rct_trip) begin
      coll_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      if (shift_in) begin
        coll_reg <= {coll_reg[BLOCK_BITS-2:0], raw_bit};
      end
      if (launch) begin
        cnt_reg <= {{(CNT_W-1){1'b0}}, accept};
      end else if (shift_in) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= '0;
    end else if (drop && ovf_reg != '1) begin
      ovf_reg <= ovf_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      tmr_reg    <= '0;
      go_reg     <= 1'b0;
      blk_reg    <= '0;
      digest_reg <= '0;
      idx_reg    <= '0;
      valid_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (launch) begin
            blk_reg   <= coll_reg;
            go_reg    <= 1'b1;
            tmr_reg   <= '0;
            state_reg <= ST_HASH;
          end
        end
        ST_HASH: begin
          if (sha_done) begin
            digest_reg <= sha_data_out;
            go_reg     <= 1'b0;
            idx_reg    <= '0;
            state_reg  <= ST_DRAIN;
          end else if (tmr_reg == TMR_LAST) begin
            go_reg    <= 1'b0;
            err_reg   <= 1'b1;
            state_reg <= ST_IDLE;
          end else begin
            tmr_reg <= tmr_reg + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!valid_reg) begin
            valid_reg <= 1'b1;
          end else if (rnd_ready) begin
            if (idx_reg == IDX_LAST) begin
              valid_reg <= 1'b0;
              state_reg <= ST_IDLE;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Word 0 is the most significant 32 bits of the digest.
  logic [WORD_W-1:0] word_arr [DIGEST_WORDS];
  for (genvar gi = 0; gi < DIGEST_WORDS; gi++) begin : g_word
    assign word_arr[gi] = digest_reg[DIGEST_BITS-1-WORD_W*gi -: WORD_W];
  end

  assign rnd_data    = word_arr[idx_reg];
  assign rnd_valid   = valid_reg;
  assign sha_go      = go_reg;
  assign sha_data_in = blk_reg;
  assign ovf_cnt     = ovf_reg;
  assign err_timeout = err_reg;

`ifdef TRNG_COND_HEALTH_EN
  logic health_reg;

  trng_rct_monitor #(
    .CUTOFF(RCT_CUTOFF)
  ) u_rct (
    .clk      (clk),
    .rst      (rst),
    .bit_valid(accept),
    .bit_in   (raw_bit),
    .trip     (rct_trip)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      health_reg <= 1'b0;
    end else if (rct_trip) begin
      health_reg <= 1'b1;
    end
  end

  assign health_fail = health_reg;
`else
  assign rct_trip    = 1'b0;
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_conditioner.sv
// Directed bench for trng_conditioner: scoreboarded blocks/words against a queue model plus a hash stand-in.
module tb_trng_conditioner;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         raw_bit;
  logic         raw_valid;
  logic         sha_go;
  logic [511:0] sha_data_in;
  logic [255:0] sha_data_out;
  logic         sha_done;
  logic [31:0]  rnd_data;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [7:0]   ovf_cnt;
  logic         err_timeout;
  logic         health_fail;

  trng_conditioner dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .raw_bit     (raw_bit),
    .raw_valid   (raw_valid),
    .sha_go      (sha_go),
    .sha_data_in (sha_data_in),
    .sha_data_out(sha_data_out),
    .sha_done    (sha_done),
    .rnd_data    (rnd_data),
    .rnd_valid   (rnd_valid),
    .rnd_ready   (rnd_ready),
    .ovf_cnt     (ovf_cnt),
    .err_timeout (err_timeout),
    .health_fail (health_fail)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] KEY =
    256'h01234567_89abcdef_fedcba98_76543210_0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state
  bit           bq[$];
  logic [511:0] exp_blocks[$];
  logic [31:0]  exp_words[$];
  logic [31:0]  rx[$];
  logic [511:0] cur_blk = '0;
  logic [511:0] seen_blk = '0;
  int exp_go_cyc = -1;
  int done_cyc = -1;
  int go_rises = 0;
  int beats = 0;
  int drops = 0;
  int last_acc_cyc = 0;
  bit chain_chk = 0;
  bit prev_go = 0;
  bit prev_valid = 0;

  // Hash / consumer stand-ins
  int hash_lat = 64;
  int go_cnt = 0;
  int last_go_len = 0;
  int ready_mode = 0;
  bit stray_done = 0;

  function automatic logic [255:0] model_digest(input logic [511:0] b);
    return b[511:256] ^ b[255:0] ^ KEY;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event occurred, required none", name);
  endtask

  always @(posedge clk) begin
    logic [255:0] d;
    #1;
    if (sha_go) begin
      go_cnt++;
    end else begin
      if (go_cnt > 0) last_go_len = go_cnt;
      go_cnt = 0;
    end
    if (sha_go && hash_lat > 0 && go_cnt == hash_lat) begin
      d = model_digest(cur_blk);
      sha_done = 1'b1;
      sha_data_out = d;
      for (int k = 0; k < 8; k++) exp_words.push_back(d[255-32*k -: 32]);
      done_cyc = cyc + 1;
    end else begin
      sha_done = stray_done;
      sha_data_out = stray_done ? ~KEY : '0;
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       rnd_ready = 1'b1;
      1:       rnd_ready = (cyc % 3 == 0);
      default: rnd_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (sha_go && !prev_go) begin
        go_rises++;
        seen_blk = sha_data_in;
        if (exp_go_cyc >= 0) begin
          check("launch_latency", cyc, exp_go_cyc);
          exp_go_cyc = -1;
        end
        if (exp_blocks.size() == 0) fail_now("unexpected_launch");
        else cur_blk = exp_blocks.pop_front();
      end
      if (sha_go) check("sha_data_in", sha_data_in, cur_blk);
      if (rnd_valid && !prev_valid && done_cyc >= 0) begin
        check("rnd_valid_latency", cyc, done_cyc + 1);
        done_cyc = -1;
      end
      if (rnd_valid) begin
        if (exp_words.size() == 0) begin
          fail_now("spurious_rnd_valid");
        end else begin
          check("rnd_data", rnd_data, exp_words[0]);
          if (rnd_ready) begin
            rx.push_back(rnd_data);
            void'(exp_words.pop_front());
            beats++;
            $display("beat %0d word %h", beats, rnd_data);
            if (exp_words.size() == 0 && chain_chk) begin
              exp_go_cyc = cyc + 2;
              chain_chk = 0;
            end
          end
        end
      end
    end
    prev_go = sha_go;
    prev_valid = rnd_valid;
  end

  // kind: 0 accepted+modelled, 1 en=0 (ignored), 2 dropped on overflow, 3 accepted but never launched
  task automatic put_bit(input logic b, input int kind);
    logic [511:0] blk;
    en = (kind != 1);
    raw_valid = 1'b1;
    raw_bit = b;
    @(posedge clk);
    #1;
    if (kind == 0) begin
      bq.push_back(b);
      if (bq.size() == 512) begin
        for (int i = 0; i < 512; i++) blk[511-i] = bq[i];
        exp_blocks.push_back(blk);
        bq.delete();
      end
    end
    if (kind == 2) drops++;
    last_acc_cyc = cyc;
  endtask

  task automatic stop_bits();
    raw_valid = 1'b0;
    en = 1'b1;
  endtask

  task automatic wait_beats(input int target, input int budget, input string name);
    int n = 0;
    while (beats < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, beats, target);
  endtask

  task automatic model_clear();
    bq.delete();
    exp_blocks.delete();
    exp_words.delete();
    done_cyc = -1;
    exp_go_cyc = -1;
  endtask

  task automatic async_reset(input string name);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check({name, "_go"}, sha_go, 1'b0);
    check({name, "_valid"}, rnd_valid, 1'b0);
    check({name, "_data"}, rnd_data, 32'h0);
    check({name, "_ovf"}, ovf_cnt, 8'h0);
    check({name, "_err"}, err_timeout, 1'b0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] alt;
    int n;
    int r0;
    int b0;
    alt = {256{2'b10}};
    rst = 1'b1; en = 1'b0; raw_bit = 1'b0; raw_valid = 1'b0;
    sha_done = 1'b0; sha_data_out = '0; rnd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_go", sha_go, 1'b0);
    check("rst_data_in", sha_data_in, '0);
    check("rst_valid", rnd_valid, 1'b0);
    check("rst_data", rnd_data, 32'h0);
    check("rst_ovf", ovf_cnt, 8'h0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_health", health_fail, 1'b0);
    rst = 1'b0;
    en = 1'b1;

    // Alternating 1,0 block, 64-cycle hash, consumer always ready; stray sha_done while idle first
    hash_lat = 64; ready_mode = 0;
    stray_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 stray_done = 1'b0;
    for (int i = 0; i < 512; i++) put_bit((i % 2 == 0), 0);
    stop_bits();
    exp_go_cyc = last_acc_cyc + 1;
    wait_beats(8, 300, "t1_beats");
    check("t1_block_literal", seen_blk, alt);
    check("t1_go_len", last_go_len, 64);
    check("t1_word0_literal", rx[0], 32'h01234567);
    check("t1_word7_literal", rx[7], 32'hc3d2e1f0);
    repeat (3) @(negedge clk);
    check("t1_valid_low", rnd_valid, 1'b0);

    // Stalled consumer (ready 1 in 3), with an en=0 pause mid-block
    ready_mode = 1;
    for (int i = 0; i < 256; i++) put_bit(((i * 37) % 5) < 2, 0);
    for (int i = 0; i < 50; i++) put_bit(1'b1, 1);
    for (int i = 256; i < 512; i++) put_bit(((i * 37) % 5) < 2, 0);
    stop_bits();
    exp_go_cyc = last_acc_cyc + 1;
    wait_beats(16, 600, "t2_beats");
    check("t2_go_len", last_go_len, 64);

    // Hash never completes: timeout after 1024 cycles; 88 bits carry into next block
    ready_mode = 0; hash_lat = 0;
    for (int i = 0; i < 600; i++) put_bit((i % 3 == 0), 0);
    stop_bits();
    n = 0;
    while (!err_timeout && n < 1200) begin
      @(negedge clk);
      n++;
    end
    check("t3_err", err_timeout, 1'b1);
    check("t3_go_low", sha_go, 1'b0);
    check("t3_go_len", last_go_len, 1024);
    check("t3_no_words", beats, 16);
    check("t3_carry_bits", bq.size(), 88);

    // Drain stalled: second buffer fills, then overflow saturates
    ready_mode = 2; hash_lat = 8;
    for (int i = 0; i < 424; i++) put_bit((i % 3 == 0), 0);
    for (int i = 0; i < 512; i++) put_bit((i % 3 == 0), 0);
    check("t4_ovf_zero", ovf_cnt, 8'd0);
    for (int i = 0; i < 100; i++) put_bit(i[0], 2);
    check("t4_ovf_100", ovf_cnt, drops);
    for (int i = 0; i < 200; i++) put_bit(i[0], 2);
    check("t4_ovf_sat", ovf_cnt, (drops > 255) ? 255 : drops);
    stop_bits();
    chain_chk = 1;
    ready_mode = 0;
    wait_beats(32, 300, "t4_beats");
    check("t4_go_len", last_go_len, 8);
    check("t4_ovf_hold", ovf_cnt, 8'd255);

    // Reset mid-HASH
    hash_lat = 0;
    for (int i = 0; i < 512; i++) put_bit(i[0], 0);
    stop_bits();
    repeat (5) @(posedge clk);
    async_reset("t5_hash");

    // Reset mid-DRAIN
    hash_lat = 8; ready_mode = 2;
    for (int i = 0; i < 512; i++) put_bit(i[0], 0);
    stop_bits();
    n = 0;
    while (!rnd_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5_drain_reached", rnd_valid, 1'b1);
    async_reset("t5_drain");

    // After reset a full fresh block is needed to launch
    ready_mode = 0; hash_lat = 64;
    r0 = go_rises;
    b0 = beats;
    for (int i = 0; i < 300; i++) put_bit(((i * 37) % 5) < 2, 0);
    stop_bits();
    repeat (20) @(posedge clk);
    #1;
    check("t5_no_relaunch", go_rises, r0);
    check("t5_go_idle", sha_go, 1'b0);
    for (int i = 300; i < 512; i++) put_bit(((i * 37) % 5) < 2, 0);
    stop_bits();
    wait_beats(b0 + 8, 300, "t5_relaunch_beats");

    // Long run of zeros
    r0 = go_rises;
    b0 = beats;
`ifdef TRNG_COND_HEALTH_EN
    put_bit(1'b1, 3);
    for (int i = 0; i < 34; i++) put_bit(1'b0, 3);
    check("t6_health_set", health_fail, 1'b1);
    for (int i = 0; i < 512; i++) put_bit((i % 2 == 0), 3);
    stop_bits();
    repeat (30) @(posedge clk);
    #1;
    check("t6_no_launch", go_rises, r0);
    check("t6_go_low", sha_go, 1'b0);
    check("t6_health_sticky", health_fail, 1'b1);
`else
    put_bit(1'b1, 0);
    for (int i = 0; i < 34; i++) put_bit(1'b0, 0);
    check("t6_health_clear", health_fail, 1'b0);
    for (int i = 0; i < 477; i++) put_bit((i % 2 == 0), 0);
    stop_bits();
    wait_beats(b0 + 8, 300, "t6_beats");
    check("t6_launched", go_rises, r0 + 1);
    check("t6_health_final", health_fail, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
